// File: rtl/hc595_serial_driver_if.sv
// hc595_serial_driver_if
//   Groups the word/enable inputs and the three 74HC595 pins of the
//   serial driver into one bundle.
//   Signals:
//     Data  [DATA_W-1:0]  word to send (Data[15] ends in the far chip's QH)
//     S_EN                send enable, level-sensitive continuous refresh
//     SH_CP               74HC595 shift clock (shift on rising edge)
//     ST_CP               74HC595 storage/latch clock (latch on rising edge)
//     DS                  serial data into the first chip
//   Modports:
//     master  the user side: drives Data/S_EN, observes the chip pins
//     slave   the driver itself: takes Data/S_EN, drives the chip pins
//   Handshake: there is no valid/ready pair. S_EN is a level; Data is
//   sampled only at frame start, so it may change freely mid-frame.
interface hc595_serial_driver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] Data;
    logic              S_EN;
    logic              SH_CP;
    logic              ST_CP;
    logic              DS;

    modport master (output Data, output S_EN, input SH_CP, input ST_CP, input DS);
    modport slave  (input Data, input S_EN, output SH_CP, output ST_CP, output DS);
endinterface

// File: rtl/hc595_serial_driver.sv
// hc595_serial_driver
//   Serialises a 16-bit word into two daisy-chained 74HC595 chips and
//   refreshes them continuously while S_EN is high. One SH_CP half-period
//   is one tick of CLK_DIV system clocks; a frame is 33 ticks: 16 pairs of
//   (set DS, raise SH_CP) followed by one latch tick raising ST_CP.
//   Ports:
//     Clk        system clock, rising edge
//     Rst_n      asynchronous active-low reset
//     bus        hc595_serial_driver_if.slave (Data, S_EN in; SH_CP, ST_CP, DS out)
//     state_dbg  1 while the FSM is in BUSY
//   Build option:
//     HC595_LSB_FIRST_EN  when defined, Data[0] is shifted first instead of
//                         Data[15]; timing is unchanged.
module hc595_serial_driver #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    hc595_serial_driver_if.slave  bus,
    output logic                  state_dbg
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int IDX_W  = $clog2(DATA_W);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LATCH = EDGE_W'(2 * DATA_W);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div_cnt, div_cnt_n;
    logic [EDGE_W-1:0]   edge_cnt, edge_cnt_n;
    logic [DATA_W-1:0]   r_data, r_data_n;
    logic                sh_cp, sh_cp_n;
    logic                st_cp, st_cp_n;
    logic                ds, ds_n;

    logic                tick;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift_src;
    logic                ds_bit;

    // Even edge k carries bit k/2 of the frame.
    assign tick    = (div_cnt == DIV_LAST);
    assign bit_idx = edge_cnt[IDX_W:1];

    // shift_src is ordered so that index 0 is the first bit on the wire.
    always_comb begin
        shift_src = '0;
`ifdef HC595_LSB_FIRST_EN
        shift_src = r_data;
`else
        for (int i = 0; i < DATA_W; i++) begin
            shift_src[i] = r_data[DATA_W-1-i];
        end
`endif
    end

    assign ds_bit = shift_src[bit_idx];

    always_comb begin
        state_n    = state;
        div_cnt_n  = tick ? '0 : div_cnt + DIV_W'(1);
        edge_cnt_n = edge_cnt;
        r_data_n   = r_data;
        sh_cp_n    = sh_cp;
        st_cp_n    = st_cp;
        ds_n       = ds;

        case (state)
            IDLE: begin
                sh_cp_n = 1'b0;
                ds_n    = 1'b0;
                if (tick) begin
                    st_cp_n = 1'b0;
                end
                if (bus.S_EN) begin
                    // Restart the divider so the first DS bit lands exactly
                    // one tick after frame start.
                    r_data_n   = bus.Data;
                    edge_cnt_n = '0;
                    div_cnt_n  = '0;
                    state_n    = BUSY;
                end
            end

            BUSY: begin
                if (tick) begin
                    if (edge_cnt == EDGE_LATCH) begin
                        sh_cp_n    = 1'b0;
                        st_cp_n    = 1'b1;
                        edge_cnt_n = '0;
                        if (bus.S_EN) begin
                            r_data_n = bus.Data;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (!edge_cnt[0]) begin
                        // Falling SH_CP half: present the next bit.
                        sh_cp_n    = 1'b0;
                        ds_n       = ds_bit;
                        edge_cnt_n = edge_cnt + EDGE_W'(1);
                        if (edge_cnt == '0) begin
                            st_cp_n = 1'b0;
                        end
                    end else begin
                        // Rising SH_CP half: DS was set one tick earlier and
                        // is left untouched across the edge.
                        sh_cp_n    = 1'b1;
                        edge_cnt_n = edge_cnt + EDGE_W'(1);
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            r_data   <= '0;
            sh_cp    <= 1'b0;
            st_cp    <= 1'b0;
            ds       <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_cnt_n;
            edge_cnt <= edge_cnt_n;
            r_data   <= r_data_n;
            sh_cp    <= sh_cp_n;
            st_cp    <= st_cp_n;
            ds       <= ds_n;
        end
    end

    assign bus.SH_CP = sh_cp;
    assign bus.ST_CP = st_cp;
    assign bus.DS    = ds;
    assign state_dbg = (state == BUSY);

endmodule

// File: tb/tb_hc595_serial_driver.sv
// tb_hc595_serial_driver
//   Directed bench for hc595_serial_driver at CLK_DIV=4, DATA_W=16.
//   A negedge monitor rebuilds each shifted frame from DS at every SH_CP
//   rise and logs latch times; the tasks compare those against
//   hand-computed frames and cycle offsets.
module tb_hc595_serial_driver;

    localparam int FRAME_CLKS = 132;

`ifdef HC595_LSB_FIRST_EN
    localparam logic [15:0] EXP_AF65 = 16'hA6F5;
    localparam logic [15:0] EXP_55A5 = 16'hA5AA;
`else
    localparam logic [15:0] EXP_AF65 = 16'hAF65;
    localparam logic [15:0] EXP_55A5 = 16'h55A5;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic state_dbg;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    hc595_serial_driver_if #(.DATA_W(16)) bus ();

    hc595_serial_driver #(.CLK_DIV(4), .DATA_W(16)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- monitor / scoreboard ----------------
    int          n_vec;
    int          n_miss;
    logic [15:0] exp_q[$];
    logic [15:0] got_frames[$];
    int          got_nbits[$];
    int          st_cyc[$];
    int          st_high[$];
    logic [15:0] bits;
    int          nbits;
    int          first_rise_cyc;
    int          ds_viol;
    int          st_run;
    logic        prev_sh, prev_st, prev_ds, rose_last, ds_at_rise;

    initial begin
        n_vec = 0; n_miss = 0; bits = '0; nbits = 0; first_rise_cyc = -1;
        ds_viol = 0; st_run = 0; prev_sh = 0; prev_st = 0; prev_ds = 0;
        rose_last = 0; ds_at_rise = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sh = 0; prev_st = 0; prev_ds = 0; rose_last = 0;
            bits = '0; nbits = 0; st_run = 0;
        end else begin
            if (rose_last && bus.DS !== ds_at_rise) ds_viol++;
            rose_last = 0;
            if (bus.SH_CP && !prev_sh) begin
                if (bus.DS !== prev_ds) ds_viol++;
                bits = {bits[14:0], bus.DS};
                nbits++;
                if (nbits == 1) first_rise_cyc = cyc;
                rose_last  = 1;
                ds_at_rise = bus.DS;
            end
            if (bus.ST_CP && !prev_st) begin
                got_frames.push_back(bits);
                got_nbits.push_back(nbits);
                st_cyc.push_back(cyc);
                bits = '0;
                nbits = 0;
            end
            if (bus.ST_CP) st_run++;
            else if (prev_st) begin
                st_high.push_back(st_run);
                st_run = 0;
            end
            prev_sh = bus.SH_CP;
            prev_st = bus.ST_CP;
            prev_ds = bus.DS;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        got_frames.delete();
        got_nbits.delete();
        st_cyc.delete();
        st_high.delete();
        ds_viol = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (got_frames.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got_frames.size() < n) begin
            n_vec++; n_miss++;
            $display("FAIL %s_timeout: frames seen %0d, required %0d", tag, got_frames.size(), n);
        end
    endtask

    task automatic wait_bits(input int n, input string tag);
        int k;
        k = 0;
        while (nbits < n && k < 300) begin
            step();
            k++;
        end
        if (nbits < n) begin
            n_vec++; n_miss++;
            $display("FAIL %s_timeout: bits seen %0d, required %0d", tag, nbits, n);
        end
    endtask

    // Pops one expected and one observed frame and compares them.
    task automatic check_frame(input string tag);
        logic [15:0] e, g;
        int          nb;
        if (got_frames.size() == 0 || exp_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s_missing: observed %0d frames, expected %0d", tag, got_frames.size(), exp_q.size());
        end else begin
            e  = exp_q.pop_front();
            g  = got_frames.pop_front();
            nb = got_nbits.pop_front();
            n_vec++;
            if (g !== e) begin
                n_miss++;
                $display("FAIL %s_word: got %h, expected %h", tag, g, e);
            end
            n_vec++;
            if (nb !== 16) begin
                n_miss++;
                $display("FAIL %s_nbits: got %0d SH_CP rises, expected 16", tag, nb);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int c0;
        clear_logs();
        rst_n = 1'b0;
        bus.S_EN = 1'b1;
        bus.Data = 16'hAF65;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 10 || i == 19) begin
                n_vec++;
                if ({bus.SH_CP, bus.ST_CP, bus.DS, state_dbg} !== 4'b0000) begin
                    n_miss++;
                    $display("FAIL reset_outputs: SH/ST/DS/busy = %b, expected 0000",
                             {bus.SH_CP, bus.ST_CP, bus.DS, state_dbg});
                end
            end
        end
        rst_n = 1'b1;
        c0 = cyc;
        exp_q.push_back(EXP_AF65);
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (bus.DS !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ds_early: DS %b at +4, expected 0", bus.DS);
        end
        step();
        n_vec++;
        if (bus.DS !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_ds_first: DS %b at +5, expected 1", bus.DS);
        end
        wait_frames(1, 200, "reset");
        n_vec++;
        if (first_rise_cyc != c0 + 9) begin
            n_miss++;
            $display("FAIL reset_first_rise: cycle %0d, expected %0d", first_rise_cyc, c0 + 9);
        end
        if (st_cyc.size() > 0) begin
            n_vec++;
            if (st_cyc[0] != c0 + 1 + FRAME_CLKS) begin
                n_miss++;
                $display("FAIL reset_latch_time: cycle %0d, expected %0d", st_cyc[0], c0 + 1 + FRAME_CLKS);
            end
        end
        check_frame("reset");
    endtask

    task automatic test_continuous();
        clear_logs();
        for (int i = 0; i < 10; i++) exp_q.push_back(EXP_AF65);
        wait_frames(10, 11 * FRAME_CLKS + 20, "cont");
        for (int i = 1; i < st_cyc.size(); i++) begin
            n_vec++;
            if (st_cyc[i] - st_cyc[i-1] != FRAME_CLKS) begin
                n_miss++;
                $display("FAIL cont_period: frame %0d period %0d, expected %0d", i, st_cyc[i] - st_cyc[i-1], FRAME_CLKS);
            end
        end
        for (int i = 0; i < st_high.size(); i++) begin
            n_vec++;
            if (st_high[i] != 4) begin
                n_miss++;
                $display("FAIL cont_st_width: pulse %0d high %0d clocks, expected 4", i, st_high[i]);
            end
        end
        for (int i = 0; i < 10; i++) check_frame("cont");
        n_vec++;
        if (ds_viol != 0) begin
            n_miss++;
            $display("FAIL cont_ds_stable: %0d DS changes near SH_CP rise, expected 0", ds_viol);
        end
    endtask

    task automatic test_data_change();
        clear_logs();
        exp_q.push_back(EXP_AF65);
        exp_q.push_back(EXP_55A5);
        for (int i = 0; i < 40; i++) step();
        bus.Data = 16'h55A5;
        wait_frames(2, 3 * FRAME_CLKS, "dchg");
        check_frame("dchg_cur");
        check_frame("dchg_next");
    endtask

    task automatic test_sen_drop();
        int c0;
        clear_logs();
        exp_q.push_back(EXP_55A5);
        wait_bits(5, "drop");
        bus.S_EN = 1'b0;
        wait_frames(1, 2 * FRAME_CLKS, "drop");
        check_frame("drop");
        for (int i = 0; i < 8; i++) step();
        n_vec++;
        if ({bus.SH_CP, bus.ST_CP, bus.DS, state_dbg} !== 4'b0000) begin
            n_miss++;
            $display("FAIL drop_idle: SH/ST/DS/busy = %b, expected 0000",
                     {bus.SH_CP, bus.ST_CP, bus.DS, state_dbg});
        end
        for (int i = 0; i < 40; i++) step();
        n_vec++;
        if (nbits != 0 || got_frames.size() != 0) begin
            n_miss++;
            $display("FAIL drop_quiet: %0d bits %0d frames in idle, expected 0 0", nbits, got_frames.size());
        end
        clear_logs();
        bus.Data = 16'hAF65;
        bus.S_EN = 1'b1;
        c0 = cyc;
        exp_q.push_back(EXP_AF65);
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (bus.DS !== 1'b0) begin
            n_miss++;
            $display("FAIL restart_ds_early: DS %b at +4, expected 0", bus.DS);
        end
        step();
        n_vec++;
        if (bus.DS !== 1'b1) begin
            n_miss++;
            $display("FAIL restart_ds_first: DS %b at +5, expected 1", bus.DS);
        end
        wait_frames(1, 200, "restart");
        if (st_cyc.size() > 0) begin
            n_vec++;
            if (st_cyc[0] != c0 + 1 + FRAME_CLKS) begin
                n_miss++;
                $display("FAIL restart_latch_time: cycle %0d, expected %0d", st_cyc[0], c0 + 1 + FRAME_CLKS);
            end
        end
        check_frame("restart");
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_logs();
        wait_bits(8, "rmid");
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.SH_CP, bus.ST_CP, bus.DS, state_dbg} !== 4'b0000) begin
            n_miss++;
            $display("FAIL rmid_async: SH/ST/DS/busy = %b, expected 0000",
                     {bus.SH_CP, bus.ST_CP, bus.DS, state_dbg});
        end
        for (int i = 0; i < 5; i++) step();
        n_vec++;
        if (got_frames.size() != 0) begin
            n_miss++;
            $display("FAIL rmid_no_latch: %0d latch pulses, expected 0", got_frames.size());
        end
        rst_n = 1'b1;
        c0 = cyc;
        exp_q.push_back(EXP_AF65);
        wait_frames(1, 200, "rmid");
        if (st_cyc.size() > 0) begin
            n_vec++;
            if (st_cyc[0] != c0 + 1 + FRAME_CLKS) begin
                n_miss++;
                $display("FAIL rmid_latch_time: cycle %0d, expected %0d", st_cyc[0], c0 + 1 + FRAME_CLKS);
            end
        end
        check_frame("rmid");
        bus.S_EN = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n    = 1'b0;
        bus.S_EN = 1'b0;
        bus.Data = '0;
        test_reset();
        test_continuous();
        test_data_change();
        test_sen_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hc595_serial_driver.md
Name: hc595_serial_driver

Overview:
- Serialises a 16-bit word into two daisy-chained 74HC595 shift registers for the board's seven-segment / LED display path.
- Generates the shift clock (SH_CP), the serial data (DS) and the latch/storage clock (ST_CP) from the single system clock.
- While enabled, it refreshes the chips continuously, one full 16-bit frame after another.

Parameters:
- CLK_DIV, 4: system clocks per tick; one tick is one SH_CP half-period. Must be >= 2.
- DATA_W, 16: frame width in bits. Fixed at 16 for this block; the edge counter is sized from it.

Ports:
- Clk  input  1  system clock (50 MHz nominal), rising-edge.
- Rst_n  input  1  asynchronous active-low reset.
- Data  input  16  word to send; Data[15] goes to the far chip's QH.
- S_EN  input  1  send enable; level-sensitive, continuous refresh while high.
- SH_CP  output  1  74HC595 shift clock; data is shifted on its rising edge.
- ST_CP  output  1  74HC595 storage/latch clock; outputs update on its rising edge.
- DS  output  1  serial data to the first chip.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values: SH_CP=0, ST_CP=0, DS=0, div_cnt=0, edge_cnt=0, shadow register r_data=0, state=IDLE.
- Divider: div_cnt runs 0..CLK_DIV-1 in every state and wraps. A tick occurs on the cycle where div_cnt==CLK_DIV-1.
- IDLE, S_EN=1: on that cycle load r_data<=Data, set edge_cnt=0, div_cnt=0, go to BUSY.
- IDLE, S_EN=0: stay in IDLE. SH_CP and DS hold 0. On any tick, clear ST_CP to 0.
- BUSY: on each tick, act on the current edge_cnt, then increment it:
  - even k in 0..30: SH_CP<=0, DS<=r_data[15-k/2] (MSB first). At k=0 also ST_CP<=0.
  - odd k in 1..31: SH_CP<=1, which shifts in the DS value set one tick earlier. DS is held stable across the rising edge.
  - k=32: SH_CP stays 0, ST_CP<=1 (latch). Then:
    - S_EN=1: r_data<=Data, edge_cnt<=0, stay in BUSY.
    - S_EN=0: edge_cnt<=0, go to IDLE.
- Frame timing:
  - One frame is 33 ticks = 33*CLK_DIV clocks (132 clocks at default).
  - Each frame has exactly 16 SH_CP rising edges and one ST_CP rising edge, after the last shift.
  - ST_CP stays high for exactly one tick.
- Latency: first DS bit becomes valid CLK_DIV clocks after the BUSY entry cycle. First SH_CP rise follows 2*CLK_DIV clocks after BUSY entry.
- Data capture: Data is sampled only at frame start (IDLE exit, or tick 32 with S_EN=1). Changes to Data mid-frame do not affect the frame in progress.
- S_EN deassert mid-frame: the current frame always completes, including its latch, before IDLE.
- Reset mid-frame: reset dominates immediately, asynchronously; no latch pulse is emitted. After release with S_EN=1, a fresh frame starts.

Optional Feature:
- Macro HC595_LSB_FIRST_EN.
  - Defined: the even-tick DS source becomes r_data[k/2], so Data[0] is shifted first and Data[15] ends in the first chip's QA.
  - Undefined (default): MSB-first as in Behaviour.
  - Timing is identical either way.

Test Plan:
- Reset held 20 clocks with S_EN=1, Data=16'hAF65 -> all outputs 0 during reset. After release, DS sampled at each SH_CP rise reads 1010_1111_0110_0101. One ST_CP rise follows, 132 clocks after BUSY entry.
- Continuous S_EN=1 for 10 frames -> frame period exactly 132 clocks; 16 SH_CP rises and 1 ST_CP rise per frame; ST_CP high exactly 4 clocks; DS never changes within 1 clock of an SH_CP rise.
- Change Data to 16'h55A5 mid-frame -> the current frame still shifts 16'hAF65; the next frame shifts 0101_0101_1010_0101.
- Drop S_EN at bit 5 of a frame -> all 16 bits plus the latch complete, then IDLE with SH_CP=DS=0 and ST_CP back to 0 within one tick. Re-raise S_EN -> a new frame starts, first DS valid CLK_DIV clocks later.
- Assert Rst_n=0 mid-frame -> outputs 0 asynchronously; no ST_CP pulse. After release, a full clean frame.
- Build with HC595_LSB_FIRST_EN, Data=16'hAF65 -> shifted sequence 1010_0110_1111_0101 (Data[0] first), same timing.
